// File: rtl/seq_divider.sv
// Multi-cycle restoring integer divider for SDIV/UDIV with a start/busy/done handshake.
// Signed operands are reduced to magnitudes, divided unsigned, then the signs are restored.
module seq_divider #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] dvd_q;
    logic             sgn_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_by_zero_q;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;
    logic             fits;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StPrep;
            StPrep:  state_d = StIter;
            StIter:  if (cnt_q == CNT_W'(1)) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q == StPrep) || (state_q == StIter) || (state_q == StFix);
        done = (state_q == StDone);
    end

    // The dividend magnitude lives in quo_q and is shifted out MSB-first into rem.
    always_comb begin
        rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
        fits      = rem_shift >= {1'b0, dvs_q};
        quo_fix   = neg_quo_q ? -quo_q : quo_q;
        rem_fix   = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            dvd_q         <= '0;
            sgn_q         <= 1'b0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        quo_q <= dividend;
                        dvd_q <= dividend;
                        dvs_q <= divisor;
                        sgn_q <= is_signed;
                    end
                end
                StPrep: begin
                    if (sgn_q && quo_q[WIDTH-1]) quo_q <= -quo_q;
                    if (sgn_q && dvs_q[WIDTH-1]) dvs_q <= -dvs_q;
                    neg_quo_q <= sgn_q & (quo_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    neg_rem_q <= sgn_q & quo_q[WIDTH-1];
                    rem_q     <= '0;
                    cnt_q     <= CNT_W'(WIDTH);
                end
                StIter: begin
                    rem_q <= fits ? rem_sub : rem_shift;
                    quo_q <= {quo_q[WIDTH-2:0], fits};
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                StFix: begin
                    // A zero divisor hands back the untouched dividend as remainder.
                    if (dvs_q == '0) begin
                        quotient_q    <= '0;
                        remainder_q   <= dvd_q;
                        div_by_zero_q <= 1'b1;
                    end else begin
                        quotient_q    <= quo_fix;
                        remainder_q   <= rem_fix;
                        div_by_zero_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule
